instr_fetch_latch: RTL and testbench
====================================

// Module: instr_fetch_latch
// PURPOSE
//   Sits between rom and decoder_with_cc. Assembles the 4-bit ROM nibble stream into a stable OPR/OPA pair,
//   detects two-word instructions (JCN, FIM, JUN, JMS, ISZ) and captures their second byte on the following
//   instruction cycle. Flags the FIN indirect-fetch cycle so the PC holds.
//   Replaces the direct rom->decoder tie (opa currently forced to 0).
// PARAMETERS
//   M1_CYCLE    3  cycle value at which rom_nibble carries OPR
//   M2_CYCLE    4  cycle value at which rom_nibble carries OPA
//   LAST_CYCLE  7  cycle value of X3; state transitions occur on the edge ending it
// PORTS
//   clk          in   1  toggle clock, same as clock_reset/pc
//   rst_n        in   1  async active-low reset
//   cycle        in   3  0..7 machine cycle from clock_reset
//   rom_nibble   in   4  rom nibble output
//   opr          out  4  first-word OPR to decoder
//   opa          out  4  first-word OPA to decoder
//   instr_valid  out  1  1-clk pulse: new first word on opr/opa
//   word2        out  8  second byte {OPR2,OPA2} of two-word instr
//   word2_valid  out  1  1-clk pulse: word2 updated
//   second_cyc   out  1  high for full instruction cycle fetching word2
//   fin_cyc      out  1  high for full FIN indirect cycle
//   pc_hold      out  1  = fin_cyc; pc must not increment this cycle
// BEHAVIOUR
//   Reset (async, rst_n=0): state=FETCH1; opr=opa=0 (NOP); word2=0; all pulses/flags 0; internal buffers 0.
//   Clock edge where cycle==M1_CYCLE: nib_hi <= rom_nibble (all states).
//   Clock edge where cycle==M2_CYCLE:
//     FETCH1: opr<=nib_hi, opa<=rom_nibble; instr_valid=1 for next clk (cycle 5) only.
//             need2 <= opr in {1,4,5,7} | (opr==2 & opa[0]==0);  needfin <= (opr==3 & opa[0]==0).
//     FETCH2: word2<={nib_hi,rom_nibble}; word2_valid=1 for next clk only; opr/opa unchanged.
//     FIN:    word2<={nib_hi,rom_nibble} (indirect data); word2_valid=1 next clk; opr/opa unchanged.
//   So opr/opa are stable from cycle 5 of first word until cycle 4 of next first word (incl. across word2).
//   FSM, evaluated on edge where cycle==LAST_CYCLE:
//     FETCH1 -> FETCH2 if need2; -> FIN if needfin; else FETCH1.
//     FETCH2 -> FETCH1.  FIN -> FETCH1.  need2/needfin cleared on leaving FETCH1.
//   second_cyc = (state==FETCH2); fin_cyc = pc_hold = (state==FIN); both registered, change only at cycle 7->0.
//   A two-word second byte is never decoded for two-word-ness (0x4x as word2 does not chain).
//   Back-to-back two-word instrs: FETCH1,FETCH2,FETCH1,FETCH2 with no idle cycle.
//   Latency: rom_nibble at M2 -> opr/opa visible 1 clk later (cycle 5); decoder must sample X1..X3.
//   Reset mid-instruction: everything cleared immediately; after release, first capture at next cycle==3,
//     treated as a first word regardless of prior state; partial nib_hi discarded.
//   No dependence on sync; cycle is the only timing reference. Out-of-order cycle values are not detected.
// TESTING
//   1. ROM 0x00,0x00 repeated -> opr=0,opa=0, instr_valid pulses once per 8 clks at cycle 5, second_cyc=0.
//   2. JUN 0x41,0x23 -> opr=4,opa=1; next cycle second_cyc=1, word2=0x23, word2_valid at cycle 5; then FETCH1.
//   3. SRC 0x21 -> one-word (opa[0]=1), second_cyc stays 0; FIM 0x20,0xAB -> word2=0xAB.
//   4. FIN 0x30 then indirect nibbles 0x5,0xC -> fin_cyc=pc_hold=1 one instr cycle, word2=0x5C, opr/opa held 3/0.
//   5. JMS 0x50,0x40 then JUN 0x40,0x00 -> word2=0x40 not chained; JUN decoded as next first word.
//   6. Assert rst_n=0 at cycle 2 of FETCH2 -> all outputs 0 instantly; after release next word is a first word.

Source files
------------

// File: rtl/instr_fetch_latch.sv
// Instruction fetch latch: assembles the ROM nibble stream into a stable OPR/OPA pair,
// captures the second byte of two-word instructions and flags the FIN indirect-fetch cycle.
module instr_fetch_latch #(
    parameter logic [2:0] M1_CYCLE   = 3'd3,
    parameter logic [2:0] M2_CYCLE   = 3'd4,
    parameter logic [2:0] LAST_CYCLE = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] cycle,
    input  logic [3:0] rom_nibble,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic       instr_valid,
    output logic [7:0] word2,
    output logic       word2_valid,
    output logic       second_cyc,
    output logic       fin_cyc,
    output logic       pc_hold
);

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        FIN    = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  nib_hi_r;
    logic [3:0]  opr_r;
    logic [3:0]  opa_r;
    logic        instr_valid_r;
    logic [7:0]  word2_r;
    logic        word2_valid_r;
    logic        need2_r;
    logic        needfin_r;
    logic        second_cyc_r;
    logic        fin_cyc_r;

    // JCN, FIM, JUN, JMS, ISZ carry a second byte
    function automatic logic is_two_word(input logic [3:0] op, input logic [3:0] arg);
        return (op == 4'd1) || (op == 4'd4) || (op == 4'd5) || (op == 4'd7) ||
               ((op == 4'd2) && (arg[0] == 1'b0));
    endfunction

    function automatic logic is_fin(input logic [3:0] op, input logic [3:0] arg);
        return (op == 4'd3) && (arg[0] == 1'b0);
    endfunction

    // Nibble capture, word assembly and fetch-state sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FETCH1;
            nib_hi_r      <= 4'd0;
            opr_r         <= 4'd0;
            opa_r         <= 4'd0;
            instr_valid_r <= 1'b0;
            word2_r       <= 8'd0;
            word2_valid_r <= 1'b0;
            need2_r       <= 1'b0;
            needfin_r     <= 1'b0;
            second_cyc_r  <= 1'b0;
            fin_cyc_r     <= 1'b0;
        end else begin
            instr_valid_r <= 1'b0;
            word2_valid_r <= 1'b0;

            if (cycle == M1_CYCLE) begin
                nib_hi_r <= rom_nibble;
            end

            if (cycle == M2_CYCLE) begin
                case (state_r)
                    FETCH1: begin
                        opr_r         <= nib_hi_r;
                        opa_r         <= rom_nibble;
                        instr_valid_r <= 1'b1;
                        need2_r       <= is_two_word(nib_hi_r, rom_nibble);
                        needfin_r     <= is_fin(nib_hi_r, rom_nibble);
                    end
                    FETCH2, FIN: begin
                        // second byte or indirect data; the first word stays on opr/opa
                        word2_r       <= {nib_hi_r, rom_nibble};
                        word2_valid_r <= 1'b1;
                    end
                    default: begin
                        word2_valid_r <= 1'b0;
                    end
                endcase
            end

            if (cycle == LAST_CYCLE) begin
                case (state_r)
                    FETCH1: begin
                        if (need2_r) begin
                            state_r      <= FETCH2;
                            second_cyc_r <= 1'b1;
                            fin_cyc_r    <= 1'b0;
                        end else if (needfin_r) begin
                            state_r      <= FIN;
                            second_cyc_r <= 1'b0;
                            fin_cyc_r    <= 1'b1;
                        end else begin
                            state_r      <= FETCH1;
                            second_cyc_r <= 1'b0;
                            fin_cyc_r    <= 1'b0;
                        end
                        need2_r   <= 1'b0;
                        needfin_r <= 1'b0;
                    end
                    default: begin
                        // FETCH2, FIN and any corrupted encoding return to a first-word fetch
                        state_r      <= FETCH1;
                        second_cyc_r <= 1'b0;
                        fin_cyc_r    <= 1'b0;
                        need2_r      <= 1'b0;
                        needfin_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign opr         = opr_r;
    assign opa         = opa_r;
    assign instr_valid = instr_valid_r;
    assign word2       = word2_r;
    assign word2_valid = word2_valid_r;
    assign second_cyc  = second_cyc_r;
    assign fin_cyc     = fin_cyc_r;
    assign pc_hold     = fin_cyc_r;

endmodule

// File: tb/tb_instr_fetch_latch.sv
// Scoreboard bench for instr_fetch_latch: an instruction-level model pushes the expected
// outputs for each clock as it is driven; the sample after the edge pops and compares.
module tb_instr_fetch_latch;

    logic       clk;
    logic       rst_n;
    logic [2:0] cycle;
    logic [3:0] rom_nibble;
    logic [3:0] opr;
    logic [3:0] opa;
    logic       instr_valid;
    logic [7:0] word2;
    logic       word2_valid;
    logic       second_cyc;
    logic       fin_cyc;
    logic       pc_hold;

    instr_fetch_latch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cycle       (cycle),
        .rom_nibble  (rom_nibble),
        .opr         (opr),
        .opa         (opa),
        .instr_valid (instr_valid),
        .word2       (word2),
        .word2_valid (word2_valid),
        .second_cyc  (second_cyc),
        .fin_cyc     (fin_cyc),
        .pc_hold     (pc_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] opr;
        logic [3:0] opa;
        logic       iv;
        logic [7:0] w2;
        logic       w2v;
        logic       sc;
        logic       fc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp;
    int n_err;

    // model state: 0 = first word, 1 = second byte, 2 = FIN indirect
    int         m_st;
    logic [3:0] m_opr;
    logic [3:0] m_opa;
    logic [7:0] m_w2;
    logic       m_need2;
    logic       m_needfin;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_st      = 0;
        m_opr     = 4'd0;
        m_opa     = 4'd0;
        m_w2      = 8'd0;
        m_need2   = 1'b0;
        m_needfin = 1'b0;
        exp_q.delete();
    endtask

    task automatic compare_all(input exp_t e, input string ctx);
        check_val({ctx, ".opr"},         {28'd0, opr},         {28'd0, e.opr});
        check_val({ctx, ".opa"},         {28'd0, opa},         {28'd0, e.opa});
        check_val({ctx, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e.iv});
        check_val({ctx, ".word2"},       {24'd0, word2},       {24'd0, e.w2});
        check_val({ctx, ".word2_valid"}, {31'd0, word2_valid}, {31'd0, e.w2v});
        check_val({ctx, ".second_cyc"},  {31'd0, second_cyc},  {31'd0, e.sc});
        check_val({ctx, ".fin_cyc"},     {31'd0, fin_cyc},     {31'd0, e.fc});
        check_val({ctx, ".pc_hold"},     {31'd0, pc_hold},     {31'd0, e.fc});
    endtask

    // Drive one instruction cycle of byte b, starting from machine cycle start_c
    task automatic run_byte(input logic [7:0] b, input int start_c, input string ctx);
        exp_t e;
        logic [3:0] hi;
        logic [3:0] lo;
        hi = b[7:4];
        lo = b[3:0];
        for (int c = start_c; c < 8; c++) begin
            @(negedge clk);
            cycle = c[2:0];
            if (c == 3)      rom_nibble = hi;
            else if (c == 4) rom_nibble = lo;
            else             rom_nibble = 4'($urandom_range(15, 0));
            e.iv  = 1'b0;
            e.w2v = 1'b0;
            if (c == 4) begin
                if (m_st == 0) begin
                    m_opr     = hi;
                    m_opa     = lo;
                    e.iv      = 1'b1;
                    m_need2   = (hi == 4'h1) || (hi == 4'h4) || (hi == 4'h5) || (hi == 4'h7) ||
                                ((hi == 4'h2) && !lo[0]);
                    m_needfin = (hi == 4'h3) && !lo[0];
                end else begin
                    m_w2  = b;
                    e.w2v = 1'b1;
                end
            end
            if (c == 7) begin
                if (m_st == 0) m_st = m_need2 ? 1 : (m_needfin ? 2 : 0);
                else           m_st = 0;
            end
            e.opr = m_opr;
            e.opa = m_opa;
            e.w2  = m_w2;
            e.sc  = (m_st == 1);
            e.fc  = (m_st == 2);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check_val({ctx, ".queue_empty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                compare_all(e, $sformatf("%s.c%0d", ctx, c));
            end
        end
    endtask

    initial begin
        exp_t z;
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        cycle      = 3'd0;
        rom_nibble = 4'd0;
        model_reset();
        z = '0;
        #1;
        compare_all(z, "reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // NOP stream
        for (int i = 0; i < 3; i++) run_byte(8'h00, 0, $sformatf("nop%0d", i));
        // JUN 0x41,0x23
        run_byte(8'h41, 0, "jun1");
        run_byte(8'h23, 0, "jun2");
        // SRC one-word, then FIM 0x20,0xAB
        run_byte(8'h21, 0, "src");
        run_byte(8'h20, 0, "fim1");
        run_byte(8'hAB, 0, "fim2");
        // FIN with indirect data 0x5C
        run_byte(8'h30, 0, "fin1");
        run_byte(8'h5C, 0, "fin2");
        // JMS 0x50,0x40 then JUN 0x40,0x00: second byte 0x40 must not chain
        run_byte(8'h50, 0, "jms1");
        run_byte(8'h40, 0, "jms2");
        run_byte(8'h40, 0, "jun3");
        run_byte(8'h00, 0, "jun4");
        // back-to-back JCN and ISZ, then odd FIN-group (JIN, one word)
        run_byte(8'h12, 0, "jcn1");
        run_byte(8'h34, 0, "jcn2");
        run_byte(8'h70, 0, "isz1");
        run_byte(8'hFE, 0, "isz2");
        run_byte(8'h31, 0, "jin");

        // reset asserted at cycle 2 of a FETCH2 instruction cycle
        run_byte(8'h22, 0, "fim3");
        @(negedge clk);
        cycle      = 3'd0;
        rom_nibble = 4'h9;
        @(posedge clk);
        @(negedge clk);
        cycle      = 3'd1;
        @(posedge clk);
        @(negedge clk);
        cycle = 3'd2;
        check_val("pre_rst.second_cyc", {31'd0, second_cyc}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(z, "mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // next capture at cycle 3 is a first word
        run_byte(8'hD5, 3, "post_rst");
        run_byte(8'h41, 0, "post_jun1");
        run_byte(8'h99, 0, "post_jun2");
        run_byte(8'h00, 0, "post_nop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
